// File: rtl/wb_arbiter_rr.sv
// rtl/wb_arbiter_rr.sv - N-master Wishbone arbiter onto one shared RAM port
//
// Grants one master at a time to the RAM port, using either fixed priority or
// round-robin, with an optional urgent override and a no-ack timeout.
//
// Ports:
//   Clk, Rst_n          clock, asynchronous active-low reset
//   Urgent_req          promotes master URGENT_IDX at the next arbitration
//   S_wb_*              per-master slave ports, master i in slice i
//   M_wb_ram_*          shared RAM request/response
//   Grant               registered one-hot grant, zero when idle
//   Busy                high while a grant is held
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module wb_arbiter_rr #(
  parameter int N_MASTERS      = 2,
  parameter int ARB_MODE       = 1,
  parameter int URGENT_IDX     = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            Clk,
  input  logic                            Rst_n,
  input  logic                            Urgent_req,
  input  logic [N_MASTERS*`ADDR_SIZE-1:0] S_wb_addr,
  input  logic [N_MASTERS-1:0]            S_wb_cs,
  input  logic [N_MASTERS-1:0]            S_wb_we,
  input  logic [N_MASTERS*`WORD_SIZE-1:0] S_wb_wdata,
  output logic [N_MASTERS*`WORD_SIZE-1:0] S_wb_rdata,
  output logic [N_MASTERS-1:0]            S_wb_ack,
  output logic [N_MASTERS-1:0]            S_wb_err,
  output logic [`ADDR_SIZE-1:0]           M_wb_ram_addr,
  output logic                            M_wb_ram_cs,
  output logic                            M_wb_ram_we,
  output logic [`WORD_SIZE-1:0]           M_wb_ram_wdata,
  input  logic [`WORD_SIZE-1:0]           M_wb_ram_rdata,
  input  logic                            M_wb_ram_ack,
  output logic [N_MASTERS-1:0]            Grant,
  output logic                            Busy
);

  localparam int AW = `ADDR_SIZE;
  localparam int DW = `WORD_SIZE;
  localparam int IW = $clog2(N_MASTERS);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] T_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]           state;
  logic [N_MASTERS-1:0] grant_q;
  logic [IW-1:0]        gidx;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        win_idx;
  logic [TW-1:0]        tcnt;
  logic                 in_grant;
  logic                 g_cs;
  logic                 timeout_hit;
  logic                 done;

  assign in_grant = (state == ST_GRANT);
  assign g_cs     = S_wb_cs[gidx];

  // Loops run from the far end down so the last assignment is the preferred
  // candidate: lowest index (fixed) or first index at/after rr_ptr (round-robin).
  always_comb begin
    win_idx = '0;
    if (ARB_MODE == 0) begin
      for (int j = N_MASTERS - 1; j >= 0; j--) begin
        if (S_wb_cs[j]) win_idx = IW'(j);
      end
    end else begin
      for (int k = N_MASTERS - 1; k >= 0; k--) begin
        if (S_wb_cs[(int'(rr_ptr) + k) % N_MASTERS])
          win_idx = IW'((int'(rr_ptr) + k) % N_MASTERS);
      end
    end
    if (Urgent_req && S_wb_cs[URGENT_IDX]) win_idx = IW'(URGENT_IDX);
  end

  // A dropped cs ends the grant anyway, so timeout only fires while cs is held;
  // an ack in the same cycle always wins over the timeout.
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && in_grant && g_cs &&
                       !M_wb_ram_ack && (tcnt == T_LAST);
  assign done = in_grant && (M_wb_ram_ack || !g_cs || timeout_hit);

  always_comb begin
    M_wb_ram_cs    = 1'b0;
    M_wb_ram_we    = 1'b0;
    M_wb_ram_addr  = '0;
    M_wb_ram_wdata = '0;
    S_wb_ack       = '0;
    S_wb_err       = '0;
    S_wb_rdata     = '0;
    if (in_grant) begin
      M_wb_ram_cs                        = g_cs & ~timeout_hit;
      M_wb_ram_we                        = S_wb_we[gidx];
      M_wb_ram_addr                      = S_wb_addr[int'(gidx)*AW +: AW];
      M_wb_ram_wdata                     = S_wb_wdata[int'(gidx)*DW +: DW];
      S_wb_ack[gidx]                     = M_wb_ram_ack;
      S_wb_err[gidx]                     = timeout_hit;
      S_wb_rdata[int'(gidx)*DW +: DW]    = M_wb_ram_rdata;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= ST_IDLE;
      grant_q <= '0;
      gidx    <= '0;
      rr_ptr  <= '0;
      tcnt    <= '0;
    end else if (state == ST_IDLE) begin
      if (|S_wb_cs) begin
        state   <= ST_GRANT;
        grant_q <= N_MASTERS'(1) << win_idx;
        gidx    <= win_idx;
        tcnt    <= '0;
      end
    end else if (done) begin
      // Completion, abort and timeout all hand priority past the granted master.
      state   <= ST_IDLE;
      grant_q <= '0;
      tcnt    <= '0;
      rr_ptr  <= (int'(gidx) == N_MASTERS - 1) ? '0 : gidx + 1'b1;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign Grant = grant_q;
  assign Busy  = in_grant;

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// tb/tb_wb_arbiter_rr.sv - self-checking bench for wb_arbiter_rr
module tb_wb_arbiter_rr;

  localparam int N  = 4;
  localparam int U  = 3;
  localparam int T  = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  logic            Clk = 1'b0;
  logic            Rst_n;
  logic            urg;
  logic [N*AW-1:0] s_addr;
  logic [N-1:0]    s_cs, s_we;
  logic [N*DW-1:0] s_wdata;
  logic [DW-1:0]   ram_rdata;
  logic            ram_ack;

  // DUT a: round-robin, DUT b: fixed priority; both see identical inputs.
  logic [N*DW-1:0] a_rdata, b_rdata;
  logic [N-1:0]    a_ack, b_ack, a_err, b_err, a_grant, b_grant;
  logic [AW-1:0]   a_raddr, b_raddr;
  logic [DW-1:0]   a_rwdata, b_rwdata;
  logic            a_rcs, b_rcs, a_rwe, b_rwe, a_busy, b_busy;

  int n_cmp = 0;
  int n_bad = 0;

  int m_busy[2], m_g[2], m_ptr[2], m_cnt[2];
  logic [DW-1:0] mem [0:255];

  always #5 Clk = ~Clk;

  wb_arbiter_rr #(.N_MASTERS(N), .ARB_MODE(1), .URGENT_IDX(U), .TIMEOUT_CYCLES(T)) dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .Urgent_req(urg),
    .S_wb_addr(s_addr), .S_wb_cs(s_cs), .S_wb_we(s_we), .S_wb_wdata(s_wdata),
    .S_wb_rdata(a_rdata), .S_wb_ack(a_ack), .S_wb_err(a_err),
    .M_wb_ram_addr(a_raddr), .M_wb_ram_cs(a_rcs), .M_wb_ram_we(a_rwe), .M_wb_ram_wdata(a_rwdata),
    .M_wb_ram_rdata(ram_rdata), .M_wb_ram_ack(ram_ack),
    .Grant(a_grant), .Busy(a_busy));

  wb_arbiter_rr #(.N_MASTERS(N), .ARB_MODE(0), .URGENT_IDX(U), .TIMEOUT_CYCLES(T)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .Urgent_req(urg),
    .S_wb_addr(s_addr), .S_wb_cs(s_cs), .S_wb_we(s_we), .S_wb_wdata(s_wdata),
    .S_wb_rdata(b_rdata), .S_wb_ack(b_ack), .S_wb_err(b_err),
    .M_wb_ram_addr(b_raddr), .M_wb_ram_cs(b_rcs), .M_wb_ram_we(b_rwe), .M_wb_ram_wdata(b_rwdata),
    .M_wb_ram_rdata(ram_rdata), .M_wb_ram_ack(ram_ack),
    .Grant(b_grant), .Busy(b_busy));

  typedef struct {
    logic [3:0] cs;
    logic       urg;
    logic       ack;
    logic [3:0] pre_ack_rr;
    logic [3:0] pre_ack_fx;
    logic [3:0] pre_err;
    logic [3:0] post_rr;
    logic [3:0] post_fx;
  } vec_t;

  vec_t tbl[23];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Winner chosen straight from the arbitration rules: urgent first, then scan
  // the candidate order (plain index order, or rotated to start at the pointer).
  function automatic int pick(input int md);
    if (urg && s_cs[U]) return U;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (md == 1) ? k : (m_ptr[md] + k) % N;
      if (s_cs[j]) return j;
    end
    return 0;
  endfunction

  function automatic bit tmo(input int md);
    return m_busy[md] != 0 && !ram_ack && s_cs[m_g[md]] && m_cnt[md] == T - 1;
  endfunction

  task automatic check_model(input int md);
    logic [N-1:0]    eg, eack, eerr;
    logic [N*DW-1:0] erd;
    logic            ecs, ewe;
    logic [AW-1:0]   eaddr;
    logic [DW-1:0]   ewd;
    string           p;
    int              g;
    eg = '0; eack = '0; eerr = '0; erd = '0; ecs = 0; ewe = 0; eaddr = '0; ewd = '0;
    g = m_g[md];
    p = (md == 0) ? "rr" : "fx";
    if (m_busy[md] != 0) begin
      eg[g]   = 1'b1;
      ecs     = s_cs[g] && !tmo(md);
      ewe     = s_we[g];
      eaddr   = s_addr[g*AW +: AW];
      ewd     = s_wdata[g*DW +: DW];
      eack[g] = ram_ack;
      eerr[g] = tmo(md);
      erd[g*DW +: DW] = ram_rdata;
    end
    chk({p, " grant"},     md == 0 ? a_grant  : b_grant,  eg);
    chk({p, " busy"},      md == 0 ? a_busy   : b_busy,   m_busy[md] != 0);
    chk({p, " ram_cs"},    md == 0 ? a_rcs    : b_rcs,    ecs);
    chk({p, " ram_we"},    md == 0 ? a_rwe    : b_rwe,    ewe);
    chk({p, " ram_addr"},  md == 0 ? a_raddr  : b_raddr,  eaddr);
    chk({p, " ram_wdata"}, md == 0 ? a_rwdata : b_rwdata, ewd);
    chk({p, " ack"},       md == 0 ? a_ack    : b_ack,    eack);
    chk({p, " err"},       md == 0 ? a_err    : b_err,    eerr);
    chk({p, " rdata"},     md == 0 ? a_rdata  : b_rdata,  erd);
  endtask

  task automatic step_model(input int md);
    if (m_busy[md] == 0) begin
      if (s_cs != 0) begin
        m_g[md] = pick(md); m_busy[md] = 1; m_cnt[md] = 0;
      end
    end else if (ram_ack || !s_cs[m_g[md]] || tmo(md)) begin
      m_busy[md] = 0;
      m_ptr[md]  = (m_g[md] + 1) % N;
      m_cnt[md]  = 0;
    end else begin
      m_cnt[md]++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " rr grant"}, a_grant, 0);  chk({tag, " fx grant"}, b_grant, 0);
    chk({tag, " rr busy"},  a_busy, 0);   chk({tag, " fx busy"},  b_busy, 0);
    chk({tag, " rr ack"},   a_ack, 0);    chk({tag, " fx ack"},   b_ack, 0);
    chk({tag, " rr err"},   a_err, 0);    chk({tag, " fx err"},   b_err, 0);
    chk({tag, " rr rdata"}, a_rdata, 0);  chk({tag, " fx rdata"}, b_rdata, 0);
    chk({tag, " rr ram"},   {a_rcs, a_rwe, a_raddr, a_rwdata}, 0);
    chk({tag, " fx ram"},   {b_rcs, b_rwe, b_raddr, b_rwdata}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            cs       urg   ack   ack_rr   ack_fx   err      post_rr  post_fx
    tbl[0]  = '{4'b1010, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010};
    tbl[1]  = '{4'b1010, 1'b0, 1'b1, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{4'b1010, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0010};
    tbl[3]  = '{4'b1010, 1'b0, 1'b1, 4'b1000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b1001, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000};
    tbl[5]  = '{4'b1001, 1'b0, 1'b1, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    tbl[6]  = '{4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[7]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
    tbl[8]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
    tbl[9]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
    tbl[10] = '{4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
    tbl[11] = '{4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
    tbl[12] = '{4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
    tbl[13] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[14] = '{4'b0011, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0001};
    tbl[15] = '{4'b0011, 1'b0, 1'b1, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[16] = '{4'b0011, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
    tbl[17] = '{4'b0000, 1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[18] = '{4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
    tbl[19] = '{4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
    tbl[20] = '{4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
    tbl[21] = '{4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
    tbl[22] = '{4'b0100, 1'b0, 1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};

    // Reset with busy inputs: every output must read zero.
    Rst_n = 1'b0; urg = 1'b1; s_cs = '1; s_we = '1;
    s_addr = {N{32'h1234_5678}}; s_wdata = {N{32'hCAFE_F00D}};
    ram_rdata = 32'hFFFF_FFFF; ram_ack = 1'b1;
    #12;
    chk_all_zero("reset");
    @(negedge Clk);
    s_cs = '0; s_we = '0; urg = 1'b0; ram_ack = 1'b0; ram_rdata = '0; Rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      @(negedge Clk);
      s_cs = tbl[i].cs; urg = tbl[i].urg; ram_ack = tbl[i].ack;
      #1;
      chk($sformatf("tbl[%0d] rr ack", i), a_ack, tbl[i].pre_ack_rr);
      chk($sformatf("tbl[%0d] fx ack", i), b_ack, tbl[i].pre_ack_fx);
      chk($sformatf("tbl[%0d] rr err", i), a_err, tbl[i].pre_err);
      chk($sformatf("tbl[%0d] fx err", i), b_err, tbl[i].pre_err);
      @(posedge Clk); #1;
      chk($sformatf("tbl[%0d] rr grant", i), a_grant, tbl[i].post_rr);
      chk($sformatf("tbl[%0d] fx grant", i), b_grant, tbl[i].post_fx);
      chk($sformatf("tbl[%0d] rr busy", i), a_busy, |tbl[i].post_rr);
    end

    // Reset during a grant: outputs drop without a clock edge, pointer restarts.
    @(negedge Clk);
    s_cs = 4'b0100; ram_ack = 1'b0; urg = 1'b0;
    @(posedge Clk); #1;
    chk("midrst rr grant before", a_grant, 4'b0100);
    @(negedge Clk);
    ram_ack = 1'b1; ram_rdata = 32'hDEAD_BEEF;
    #1;
    chk("midrst rr ack before", a_ack, 4'b0100);
    #2 Rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge Clk);
    Rst_n = 1'b1; ram_ack = 1'b0; ram_rdata = '0; s_cs = 4'b1010;
    @(posedge Clk); #1;
    chk("postrst rr grant", a_grant, 4'b0010);
    @(negedge Clk); ram_ack = 1'b1;
    @(posedge Clk);
    @(negedge Clk); ram_ack = 1'b0; s_cs = '0;
    @(posedge Clk);

    // Write through master 1, read back through master 0.
    @(negedge Clk);
    s_cs = 4'b0010; s_we = 4'b0010;
    s_addr[1*AW +: AW] = 32'h10; s_wdata[1*DW +: DW] = 32'hA5A5_A5A5;
    @(posedge Clk); #1;
    chk("wr grant", a_grant, 4'b0010);
    chk("wr ram_cs", a_rcs, 1'b1);
    chk("wr ram_we", a_rwe, 1'b1);
    chk("wr ram_addr", a_raddr, 32'h10);
    chk("wr ram_wdata", a_rwdata, 32'hA5A5_A5A5);
    @(negedge Clk);
    if (a_rcs && a_rwe) mem[a_raddr[7:0]] = a_rwdata;
    ram_ack = 1'b1;
    #1;
    chk("wr ack", a_ack, 4'b0010);
    chk("wr m1 rdata", a_rdata[1*DW +: DW], 32'h0);
    @(posedge Clk);
    @(negedge Clk);
    ram_ack = 1'b0; s_cs = 4'b0001; s_we = '0; s_addr[0 +: AW] = 32'h10;
    @(posedge Clk); #1;
    chk("rd grant", a_grant, 4'b0001);
    @(negedge Clk);
    ram_rdata = mem[a_raddr[7:0]]; ram_ack = 1'b1;
    #1;
    chk("rd ack", a_ack, 4'b0001);
    chk("rd m0 rdata", a_rdata[0 +: DW], 32'hA5A5_A5A5);
    chk("rd m1 rdata", a_rdata[1*DW +: DW], 32'h0);
    chk("rd fx m0 rdata", b_rdata[0 +: DW], 32'hA5A5_A5A5);
    @(posedge Clk);
    @(negedge Clk);
    ram_ack = 1'b0; s_cs = '0; ram_rdata = '0;

    // Randomized run against the reference model.
    Rst_n = 1'b0;
    for (int md = 0; md < 2; md++) begin
      m_busy[md] = 0; m_g[md] = 0; m_ptr[md] = 0; m_cnt[md] = 0;
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clk);
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) s_cs[b] = ~s_cs[b];
      urg       = ($urandom_range(0, 7) == 0);
      ram_ack   = ($urandom_range(0, 3) == 0);
      s_we      = N'($urandom);
      s_addr    = {$urandom, $urandom, $urandom, $urandom};
      s_wdata   = {$urandom, $urandom, $urandom, $urandom};
      ram_rdata = $urandom;
      #1;
      check_model(0);
      check_model(1);
      @(posedge Clk);
      step_model(0);
      step_model(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
